// File: rtl/instr_mem_loader_if.sv
// Instruction-memory loader bus.
// Groups the byte-stream input, the instruction-memory write port and the
// CPU hold / status flags of instr_mem_loader.
//   master : stream source / memory / CPU side (drives Inicio, DadoByte, ByteValido)
//   slave  : the loader itself (drives handshake, write port and status)
interface instr_mem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              Inicio;
    logic [7:0]        DadoByte;
    logic              ByteValido;
    logic              AceitaByte;
    logic              EscritaHab;
    logic [ADDR_W-1:0] EnderecoEscrita;
    logic [31:0]       DadoEscrita;
    logic              SegurarCPU;
    logic              Concluido;
    logic              Erro;

    modport master (
        output Inicio, DadoByte, ByteValido,
        input  AceitaByte, EscritaHab, EnderecoEscrita, DadoEscrita,
        input  SegurarCPU, Concluido, Erro
    );

    modport slave (
        input  Inicio, DadoByte, ByteValido,
        output AceitaByte, EscritaHab, EnderecoEscrita, DadoEscrita,
        output SegurarCPU, Concluido, Erro
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Write side of the instruction memory. Takes a big-endian byte stream made of
// a 32-bit word count N followed by N 32-bit words, and writes word i to
// instruction-memory address i. The CPU is held in reset for the whole load.
// Ports:
//   Clock  : rising-edge clock
//   Reset  : asynchronous, active-high reset
//   bus    : instr_mem_loader_if.slave
//            Inicio/DadoByte/ByteValido in; AceitaByte handshake out;
//            EscritaHab/EnderecoEscrita/DadoEscrita write port out;
//            SegurarCPU/Concluido/Erro status out (all registered)
module instr_mem_loader #(
    parameter int DEPTH  = 24,
    parameter int ADDR_W = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    instr_mem_loader_if.slave    bus
);
    localparam int WCNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OCIOSO,
        CONTAGEM,
        DADOS,
        ESCRITA,
        FIM,
        ERRO
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [31:0]         n_q, n_d;
    logic [31:0]         word_q, word_d;
    logic                aceita_q, aceita_d;
    logic                escrita_q, escrita_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         dado_q, dado_d;
    logic                segurar_q, segurar_d;
    logic                concl_q, concl_d;
    logic                erro_q, erro_d;
    logic                xfer;

    assign xfer = bus.ByteValido & aceita_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        word_d     = word_q;
        addr_d     = addr_q;
        dado_d     = dado_q;
        segurar_d  = segurar_q;
        concl_d    = concl_q;
        erro_d     = erro_q;

        if (bus.Inicio) begin
            // Start/abort: any byte offered this cycle is dropped.
            state_d    = CONTAGEM;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            n_d        = '0;
            word_d     = '0;
            segurar_d  = 1'b1;
            concl_d    = 1'b0;
            erro_d     = 1'b0;
        end else begin
            case (state_q)
                CONTAGEM: begin
                    if (xfer) begin
                        n_d        = {n_q[23:0], bus.DadoByte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (n_d == 32'd0)
                                state_d = FIM;
                            else if (n_d > 32'(DEPTH))
                                state_d = ERRO;
                            else
                                state_d = DADOS;
                        end
                    end
                end
                DADOS: begin
                    if (xfer) begin
                        word_d     = {word_q[23:0], bus.DadoByte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_d = ESCRITA;
                            dado_d  = word_d;
                            addr_d  = ADDR_W'(word_cnt_q);
                        end
                    end
                end
                ESCRITA: begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = (32'(word_cnt_d) == n_q) ? FIM : DADOS;
                end
                FIM:     state_d = OCIOSO;
                default: ;  // OCIOSO and ERRO wait for Inicio
            endcase
        end

        // Outputs are registered, so they are decoded from the next state.
        aceita_d  = (state_d == CONTAGEM) || (state_d == DADOS);
        escrita_d = (state_d == ESCRITA);
        if (state_d == FIM) begin
            segurar_d = 1'b0;
            concl_d   = 1'b1;
        end
        if (state_d == ERRO)
            erro_d = 1'b1;  // SegurarCPU stays high: a bad image must not run
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= OCIOSO;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            n_q        <= '0;
            word_q     <= '0;
            aceita_q   <= 1'b0;
            escrita_q  <= 1'b0;
            addr_q     <= '0;
            dado_q     <= '0;
            segurar_q  <= 1'b0;
            concl_q    <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            word_q     <= word_d;
            aceita_q   <= aceita_d;
            escrita_q  <= escrita_d;
            addr_q     <= addr_d;
            dado_q     <= dado_d;
            segurar_q  <= segurar_d;
            concl_q    <= concl_d;
            erro_q     <= erro_d;
        end
    end

    assign bus.AceitaByte      = aceita_q;
    assign bus.EscritaHab      = escrita_q;
    assign bus.EnderecoEscrita = addr_q;
    assign bus.DadoEscrita     = dado_q;
    assign bus.SegurarCPU      = segurar_q;
    assign bus.Concluido       = concl_q;
    assign bus.Erro            = erro_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a program image is generated, its
// expected writes (address i gets word i) are queued, the image is streamed in
// big-endian, and a monitor pops and compares on every write strobe.
module tb_instr_mem_loader;
    localparam int DEPTH = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_W(32)) bus ();

    instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          count_en = 1'b0;
    int          gap_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst && bus.EscritaHab === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got write @%0d data 0x%08h, expected none",
                         bus.EnderecoEscrita, bus.DadoEscrita);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.EnderecoEscrita, e.addr);
                check("write_data", bus.DadoEscrita, e.data);
                check("no_accept_during_write", 32'(bus.AceitaByte), 32'd0);
            end
        end
        if (count_en && bus.SegurarCPU && !bus.AceitaByte) gap_cycles++;
    end

    task automatic pulse_inicio();
        @(negedge clk);
        bus.Inicio = 1'b1;
        @(negedge clk);
        bus.Inicio     = 1'b0;
        bus.ByteValido = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int t = 0;
        int gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (gap) begin
            @(negedge clk);
            bus.ByteValido = 1'b0;
        end
        @(negedge clk);
        bus.ByteValido = 1'b1;
        bus.DadoByte   = b;
        while (!bus.AceitaByte && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            $display("FAIL byte_accept_timeout: got AceitaByte=0 for 100 cycles, required 1");
        end
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * (3 - k))), gapmax);
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.ByteValido = 1'b0;
    endtask

    task automatic wait_done(input bit expect_err, input logic [31:0] exp_hold);
        int t = 0;
        while (!(bus.Concluido || bus.Erro) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            $display("FAIL done_timeout: got no Concluido/Erro in 200 cycles, required one");
        end
        repeat (3) @(negedge clk);
        check("concluido", 32'(bus.Concluido), expect_err ? 32'd0 : 32'd1);
        check("erro", 32'(bus.Erro), expect_err ? 32'd1 : 32'd0);
        check("segurar_cpu", 32'(bus.SegurarCPU), exp_hold);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    // Reference: word i of img lands at address i; a count above DEPTH writes nothing.
    task automatic run_load(input logic [31:0] n, input int gapmax);
        bit ok = (n <= 32'(DEPTH));
        if (ok) for (int i = 0; i < int'(n); i++) exp_q.push_back('{addr: 32'(i), data: img[i]});
        pulse_inicio();
        check("hold_after_inicio", 32'(bus.SegurarCPU), 32'd1);
        send_word(n, gapmax);
        if (ok) for (int i = 0; i < int'(n); i++) send_word(img[i], gapmax);
        release_bus();
        wait_done(!ok, ok ? 32'd0 : 32'd1);
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] n;
        rst            = 1'b1;
        bus.Inicio     = 1'b0;
        bus.ByteValido = 1'b0;
        bus.DadoByte   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_aceita",  32'(bus.AceitaByte), 32'd0);
        check("rst_escrita", 32'(bus.EscritaHab), 32'd0);
        check("rst_addr",    bus.EnderecoEscrita, 32'd0);
        check("rst_dado",    bus.DadoEscrita, 32'd0);
        check("rst_segurar", 32'(bus.SegurarCPU), 32'd0);
        check("rst_concl",   32'(bus.Concluido), 32'd0);
        check("rst_erro",    32'(bus.Erro), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // Idle: a byte offered without Inicio is ignored
        bus.ByteValido = 1'b1;
        bus.DadoByte   = 8'hAA;
        @(negedge clk);
        check("idle_no_accept", 32'(bus.AceitaByte), 32'd0);
        bus.ByteValido = 1'b0;

        // 1: two-word program
        img.delete();
        img.push_back(32'h0801_0005);
        img.push_back(32'h1400_0003);
        run_load(32'd2, 0);
        repeat (5) @(negedge clk);
        check("concluido_sticky", 32'(bus.Concluido), 32'd1);

        // 2: empty program
        img.delete();
        run_load(32'd0, 1);

        // 3: count above DEPTH, then a legal load
        run_load(32'd25, 0);
        repeat (10) @(negedge clk);
        check("erro_sticky", 32'(bus.Erro), 32'd1);
        check("erro_hold", 32'(bus.SegurarCPU), 32'd1);
        fill_img(3);
        run_load(32'd3, 2);

        // 4: continuous valid, N=3: accept drops only in the 3 write cycles
        fill_img(3);
        gap_cycles = 0;
        count_en   = 1'b1;
        run_load(32'd3, 0);
        count_en   = 1'b0;
        check("accept_gaps", 32'(gap_cycles), 32'd3);

        // 5: restart after 6 bytes of a 3-word load
        pulse_inicio();
        send_word(32'd3, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        fill_img(2);
        run_load(32'd2, 0);

        // 6: async reset mid-word
        fill_img(2);
        exp_q.push_back('{addr: 32'd0, data: img[0]});
        pulse_inicio();
        send_word(32'd2, 0);
        send_word(img[0], 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_aceita",  32'(bus.AceitaByte), 32'd0);
        check("arst_escrita", 32'(bus.EscritaHab), 32'd0);
        check("arst_addr",    bus.EnderecoEscrita, 32'd0);
        check("arst_dado",    bus.DadoEscrita, 32'd0);
        check("arst_segurar", 32'(bus.SegurarCPU), 32'd0);
        check("arst_concl",   32'(bus.Concluido), 32'd0);
        check("arst_erro",    32'(bus.Erro), 32'd0);
        check("arst_pending", 32'(exp_q.size()), 32'd0);
        bus.ByteValido = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fill_img(4);
        run_load(32'd4, 1);

        // Boundary: exactly DEPTH words
        fill_img(DEPTH);
        run_load(32'(DEPTH), 1);

        // Random legal and illegal loads
        for (int it = 0; it < 8; it++) begin
            if (it % 4 == 3) begin
                n = ($urandom % 2) ? 32'(25 + $urandom_range(0, 200)) : ($urandom | 32'h8000_0000);
                run_load(n, 2);
            end else begin
                n = 32'($urandom_range(1, DEPTH));
                fill_img(int'(n));
                run_load(n, 3);
            end
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
